// File: rtl/fxp_pkg.sv
// Shared Q6.11 fixed-point constants and the gate pre-activation MAC state type.
package fxp_pkg;

  localparam int QN       = 6;
  localparam int QM       = 11;
  localparam int BITWIDTH = QN + QM + 1;

  localparam logic signed [BITWIDTH-1:0] FXP_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] FXP_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
  localparam logic signed [BITWIDTH-1:0] FXP_ONE = BITWIDTH'(1) <<< QM;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_FINAL,
    ST_OUT
  } mac_state_t;

endpackage

// File: rtl/fxp_shift_sat.sv
// Arithmetic right shift (truncating toward -inf) followed by signed saturation
// to a narrower two's-complement width. Purely combinational.
module fxp_shift_sat #(
  parameter int IW = 40,
  parameter int SH = 11,
  parameter int OW = 18
) (
  input  logic [IW-1:0] value,
  output logic [OW-1:0] result
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [IW-1:0] shifted;

  assign shifted = $signed(value) >>> SH;

  always_comb begin
    result = shifted[OW-1:0];
    if (shifted > MAXV) begin
      result = MAXV[OW-1:0];
    end else if (shifted < MINV) begin
      result = MINV[OW-1:0];
    end
  end

endmodule

// File: rtl/gate_preact_mac.sv
// One MAC lane computing a saturated Q6.11 gate pre-activation: sum(w*x) + bias.
//
// state    | meaning
// ST_IDLE  | waiting for start; pairs ignored
// ST_ACCUM | accepting weight/data pairs, registering products
// ST_DRAIN | last product being added into the accumulator
// ST_FINAL | two cycles: add bias, then shift/saturate into result
// ST_OUT   | result held until the consumer takes it
module gate_preact_mac
  import fxp_pkg::*;
#(
  parameter int QN      = fxp_pkg::QN,
  parameter int QM      = fxp_pkg::QM,
  parameter int NINPUTS = 8,
  parameter int ACCW    = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [QN+QM:0]   bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QN+QM:0]   weight,
  input  logic [QN+QM:0]   data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QN+QM:0]   result
);

  localparam int BW = QN + QM + 1;
  localparam int CW = $clog2(NINPUTS) + 1;

  mac_state_t state, state_nx;

  logic [CW-1:0]          count;
  logic                   prod_valid;
  logic signed [2*BW-1:0] prod;
  logic [ACCW-1:0]        acc;
  logic [ACCW-1:0]        sum;
  logic [BW-1:0]          bias_q;
  logic                   fin_phase;
  logic [BW-1:0]          sat_out;
  logic [ACCW-1:0]        bias_ext;
  logic                   accept;
  logic                   last_pair;

  assign in_ready  = (state == ST_ACCUM);
  assign accept    = in_valid & in_ready;
  assign last_pair = (count == CW'(NINPUTS - 1));
  assign bias_ext  = {{(ACCW-BW){bias_q[BW-1]}}, bias_q};

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_ACCUM;
      ST_ACCUM: if (accept && last_pair) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ST_FINAL;
      ST_FINAL: if (fin_phase) state_nx = ST_OUT;
      ST_OUT:   if (out_valid && out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      prod_valid <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      sum        <= '0;
      bias_q     <= '0;
      fin_phase  <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
    end else begin
      state      <= state_nx;
      prod_valid <= accept;
      if (accept) begin
        prod  <= $signed(weight) * $signed(data);
        count <= count + CW'(1);
      end

      if (prod_valid) begin
        acc <= acc + {{(ACCW-2*BW){prod[2*BW-1]}}, prod};
      end

      if (state == ST_IDLE && start) begin
        bias_q <= bias;
        acc    <= '0;
        count  <= '0;
      end

      // Bias add and shift/saturate are split so the wide add has its own cycle.
      if (state == ST_FINAL) begin
        if (!fin_phase) begin
          sum       <= acc + (bias_ext <<< QM);
          fin_phase <= 1'b1;
        end else begin
          result    <= sat_out;
          out_valid <= 1'b1;
          fin_phase <= 1'b0;
        end
      end

      if (state == ST_OUT && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  fxp_shift_sat #(
    .IW(ACCW),
    .SH(QM),
    .OW(BW)
  ) u_shift_sat (
    .value (sum),
    .result(sat_out)
  );

endmodule

// File: tb/tb_gate_preact_mac.sv
// Directed bench for gate_preact_mac: a 4-input lane and a 1-input lane.
module tb_gate_preact_mac;
  import fxp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, in_valid, in_ready, out_valid, out_ready;
  logic [17:0] bias, weight, data, result;

  logic        start1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [17:0] bias1, weight1, data1, result1;

  int checks = 0;
  int errors = 0;

  gate_preact_mac #(.NINPUTS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .weight(weight), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  gate_preact_mac #(.NINPUTS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .bias(bias1),
    .in_valid(in_valid1), .in_ready(in_ready1), .weight(weight1), .data(data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1)
  );

  // Runs one 4-pair dot product; lat = edges from last accept to out_valid.
  task automatic do_op(input logic [17:0] w, input logic [17:0] d, input logic [17:0] b,
                       input bit rnd, input bit poke_start,
                       output logic [17:0] res, output int lat);
    int n = 0;
    int budget = 0;
    logic v;
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 4 && budget < 200) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      weight   = w;
      data     = d;
      start    = (poke_start && n == 2);
      if (v && in_ready) n++;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    lat = 0;
    if (n < 4) begin
      lat = -1;
    end else begin
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    res = result;
  endtask

  task automatic do_op1(input logic [17:0] w, input logic [17:0] d,
                        output logic [17:0] res, output int lat);
    int budget = 0;
    start1 = 1'b1;
    bias1  = 18'h0;
    @(posedge clk); #1;
    start1 = 1'b0;
    in_valid1 = 1'b1;
    weight1 = w;
    data1   = d;
    while (!in_ready1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 18'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (u_dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", u_dut.state); end
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL reset_in_ready1 got %b want 0", in_ready1); end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0 || u_dut.state !== ST_IDLE) begin
      errors++; $display("FAIL idle_ignores_valid in_ready %b state %0d want 0/IDLE", in_ready, u_dut.state);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_unity();
    logic [17:0] r; int lat;
    do_op(18'd2048, 18'd2048, 18'd0, 1'b0, 1'b0, r, lat);
    checks++; if (r !== 18'd8192) begin errors++; $display("FAIL unity_result got %h want %h", r, 18'd8192); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL unity_latency got %0d want 3", lat); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unity_consumed out_valid %b want 0", out_valid); end
  endtask

  task automatic test_signed_bias();
    logic [17:0] r; int lat;
    do_op(18'h3F800, 18'h00C00, 18'd1024, 1'b0, 1'b0, r, lat);
    checks++; if (r !== 18'h3D400) begin errors++; $display("FAIL signed_result got %h want 3d400", r); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL signed_latency got %0d want 3", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [17:0] r; int lat;
    do_op(18'h1FFFF, 18'h1FFFF, 18'd0, 1'b0, 1'b0, r, lat);
    checks++; if (r !== 18'h1FFFF) begin errors++; $display("FAIL sat_pos got %h want 1ffff", r); end
    @(posedge clk); #1;
    do_op(18'h1FFFF, 18'h20000, 18'd0, 1'b0, 1'b0, r, lat);
    checks++; if (r !== 18'h20000) begin errors++; $display("FAIL sat_neg got %h want 20000", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_truncation();
    logic [17:0] r; int lat;
    do_op1(18'd1, 18'd1, r, lat);
    checks++; if (r !== 18'h0) begin errors++; $display("FAIL trunc_pos got %h want 0", r); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL trunc_latency got %0d want 3", lat); end
    @(posedge clk); #1;
    do_op1(18'h3FFFF, 18'd1, r, lat);
    checks++; if (r !== 18'h3FFFF) begin errors++; $display("FAIL trunc_neg got %h want 3ffff", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_valid();
    logic [17:0] r; int lat;
    do_op(18'd2048, 18'd2048, 18'd0, 1'b1, 1'b0, r, lat);
    checks++; if (r !== 18'd8192) begin errors++; $display("FAIL rand_unity got %h want %h", r, 18'd8192); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rand_latency got %0d want 3", lat); end
    @(posedge clk); #1;
    do_op(18'h3F800, 18'h00C00, 18'd1024, 1'b1, 1'b0, r, lat);
    checks++; if (r !== 18'h3D400) begin errors++; $display("FAIL rand_signed got %h want 3d400", r); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_stall();
    logic [17:0] r; int lat;
    out_ready = 1'b0;
    do_op(18'd2048, 18'd2048, 18'd0, 1'b0, 1'b0, r, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || result !== 18'd8192) begin
        errors++; $display("FAIL stall_hold cycle %0d valid %b result %h want 1/02000", i, out_valid, result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || u_dut.state !== ST_IDLE) begin
      errors++; $display("FAIL stall_release valid %b state %0d want 0/IDLE", out_valid, u_dut.state);
    end
  endtask

  task automatic test_start_ignored();
    logic [17:0] r; int lat;
    do_op(18'd2048, 18'd2048, 18'd0, 1'b0, 1'b1, r, lat);
    checks++; if (r !== 18'd8192) begin errors++; $display("FAIL start_in_accum got %h want %h", r, 18'd8192); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(18'd2048, 18'd2048, 18'd0, 1'b0, 1'b0, r, lat);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (u_dut.state !== ST_IDLE || in_ready !== 1'b0) begin
      errors++; $display("FAIL start_in_out state %0d in_ready %b want IDLE/0", u_dut.state, in_ready);
    end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL start_in_out_late in_ready %b want 0", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [17:0] r; int lat;
    start = 1'b1;
    bias  = 18'd0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    weight = 18'd2048;
    data   = 18'd2048;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || u_dut.state !== ST_IDLE) begin
      errors++; $display("FAIL reset_mid in_ready %b out_valid %b state %0d want 0/0/IDLE", in_ready, out_valid, u_dut.state);
    end
    do_op(18'd2048, 18'd2048, 18'd0, 1'b0, 1'b0, r, lat);
    checks++; if (r !== 18'd8192) begin errors++; $display("FAIL reset_mid_fresh got %h want %h", r, 18'd8192); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; bias = '0; in_valid = 1'b0; weight = '0; data = '0; out_ready = 1'b1;
    start1 = 1'b0; bias1 = '0; in_valid1 = 1'b0; weight1 = '0; data1 = '0; out_ready1 = 1'b1;
    test_reset();
    test_unity();
    test_signed_bias();
    test_saturation();
    test_truncation();
    test_random_valid();
    test_out_stall();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_preact_mac.md
Name: gate_preact_mac

Overview:
- Upstream feeder for the sigmoid activation stage.
- Computes one LSTM/RNN gate pre-activation: sum over k of w[k]*x[k], plus bias.
- Operands arrive as a stream of Q6.11 weight/data pairs. The result is a saturated Q6.11 value held on `result` with `out_valid` until the consumer takes it.
- One MAC lane; a gate vector is built by instantiating several of these.

Parameters:
- QN, 6, integer bits (excluding sign) of the fixed-point format
- QM, 11, fractional bits
- NINPUTS, 8, number of weight/data pairs per dot product (>=1)
- ACCW, 40, accumulator width; must be >= 2*(QN+QM+1)+clog2(NINPUTS)+1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a new dot product, latches bias (honoured only in IDLE)
- bias  in  QN+QM+1  signed Q6.11 bias, sampled when start is accepted
- in_valid  in  1  weight/data pair valid
- in_ready  out  1  block accepts a pair this cycle
- weight  in  QN+QM+1  signed Q6.11 weight
- data  in  QN+QM+1  signed Q6.11 input element
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- result  out  QN+QM+1  signed Q6.11 saturated pre-activation

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, in_ready=0, out_valid=0, result=0, acc=0, count=0, prod_valid=0. Reset overrides all other events, including mid-ACCUM and mid-OUT; a partial sum is discarded.
- FSM states: IDLE, ACCUM, DRAIN, FINAL, OUT.
- IDLE:
  - in_ready=0.
  - start=1 → latch bias, clear acc and count, go to ACCUM.
  - in_valid is ignored.
- ACCUM:
  - in_ready=1.
  - Handshake (in_valid & in_ready): prod <= weight*data (2*BITWIDTH bits, signed, Q12.22), prod_valid <= 1, count++.
  - No handshake: prod_valid <= 0.
  - On the handshake where count == NINPUTS-1 → go to DRAIN.
- Accumulate: every edge with prod_valid=1, acc <= acc + sign_ext(prod). This is independent of state.
- DRAIN: in_ready=0. One cycle, during which the last product is added. Then go to FINAL.
- FINAL:
  - result <= sat((acc + (sign_ext(bias) <<< QM)) >>> QM).
  - out_valid <= 1; go to OUT.
- OUT:
  - result is held stable.
  - On out_valid & out_ready → out_valid <= 0, go to IDLE.
- Latency: out_valid rises on the 3rd rising edge after the edge that accepts the last pair. Minimum full-operation time is NINPUTS+4 cycles, start to out_valid.
- Arithmetic:
  - The shift is arithmetic, so it truncates toward -inf; there is no rounding.
  - Saturation clamps to [-2^(QN+QM), 2^(QN+QM)-1], i.e. [-131072, 131071] for the defaults.
  - The accumulator never wraps when ACCW meets its constraint.
- Ignored inputs:
  - start outside IDLE is ignored, including a start coinciding with the output handshake; the block reaches IDLE first.
  - in_valid outside ACCUM is ignored.
- out_ready may be held high permanently. The result is then consumed on the first out_valid cycle.

Decomposition:
- Shared package fxp_pkg:
  - QN, QM, BITWIDTH=QN+QM+1
  - FXP_MAX and FXP_MIN saturation constants
  - FXP_ONE = 1<<<QM
  - the gate_preact_mac FSM state enum
- One sub-module, fxp_shift_sat:
  - parameterised input width, shift amount and output width
  - performs the arithmetic right shift plus saturation
  - combinational only; reusable by the tanh and cell-update stages

Test Plan:
- Unity dot product: NINPUTS=4; weight=2048 (1.0), data=2048 (1.0), bias=0 → result=8192 (4.0); out_valid exactly 3 cycles after the last accept.
- Signed sum with bias: weight=-2048, data=3072 (1.5), bias=1024 (0.5), 4 pairs → result=-11264 (18'h3D400).
- Saturation: weight=data=131071, 4 pairs → result=131071. Then weight=131071, data=-131072, 4 pairs → result=-131072.
- Truncation: NINPUTS=1. weight=1, data=1, bias=0 → result=0. Then weight=-1, data=1, bias=0 → result=-1 (18'h3FFFF).
- Handshake stress:
  - in_valid random at 50% → same result as the back-to-back case.
  - out_ready held low for 5 cycles → result and out_valid stable for that time.
  - start pulsed during ACCUM and OUT → ignored.
- Reset mid-ACCUM: reset after 2 of 4 pairs → next edge in_ready=0, out_valid=0, state IDLE. A fresh start with 4 unity pairs then yields exactly 8192, with no stale partial sum.
